// File: rtl/decoder_window_arbiter_pkg.sv
// Shared types and helpers for the decoder window arbiter and its round-robin picker.
package decoder_window_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    STREAM = 2'd2,
    RESULT = 2'd3
  } state_t;

  function automatic int grant_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int window_len(input int wr);
    return 1 << wr;
  endfunction

endpackage

// File: rtl/decoder_window_arbiter_rr_arbiter_pick.sv
// Combinational round-robin search: first set request strictly after ptr, wrapping modulo NREQ.
module rr_arbiter_pick
  import decoder_window_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = grant_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   grant,
  output logic            any
);

  int idx;

  // Walk from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        grant = GW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_window_arbiter.sv
// Grants one requester a whole 2^WR-beat decoder window, then returns the result to it.
// Optional status ports oGrant/oWinCnt are enabled by DECODER_WINDOW_ARBITER_STATUS_EN.
module decoder_window_arbiter
  import decoder_window_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WDATA = 16,
  parameter int WRES  = 16,
  parameter int WR    = 8
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [NREQ-1:0]         iValid_AS,
  output logic [NREQ-1:0]         oReady_AS,
  input  logic [NREQ*WDATA-1:0]   iData_AS,
  output logic                    oValid_DS,
  input  logic                    iReady_DS,
  output logic [WDATA-1:0]        oData_DS,
  input  logic                    iValid_DB,
  output logic                    oReady_DB,
  input  logic [WRES-1:0]         iData_DB,
  output logic [NREQ-1:0]         oValid_BS,
  input  logic [NREQ-1:0]         iReady_BS,
  output logic [NREQ*WRES-1:0]    oData_BS
`ifdef DECODER_WINDOW_ARBITER_STATUS_EN
  ,
  output logic [grant_width(NREQ)-1:0] oGrant,
  output logic [15:0]                  oWinCnt
`endif
);

  localparam int            GW   = grant_width(NREQ);
  localparam logic [WR-1:0] LAST = WR'(window_len(WR) - 1);

  state_t        state;
  logic [GW-1:0] grant;
  logic [GW-1:0] ptr;
  logic [GW-1:0] pick;
  logic          pick_any;
  logic [WR-1:0] cnt;
  logic          beat_hs;
  logic          last_beat;
  logic          res_window;
  logic          res_hs;

  rr_arbiter_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req   (iValid_AS),
    .ptr   (ptr),
    .grant (pick),
    .any   (pick_any)
  );

  always_comb begin
    beat_hs    = (state == STREAM) && iValid_AS[grant] && iReady_DS;
    last_beat  = beat_hs && (cnt == LAST);
    res_window = last_beat || (state == RESULT);
    res_hs     = res_window && iValid_DB && iReady_BS[grant];
  end

  // Handshakes are masked during reset so a mid-window reset cycle shows a quiet interface.
  always_comb begin
    oValid_DS = 1'b0;
    oReady_AS = '0;
    oReady_DB = 1'b0;
    oValid_BS = '0;
    oData_DS  = iData_AS[grant*WDATA +: WDATA];
    oData_BS  = {NREQ{iData_DB}};
    if (!iRST) begin
      if (state == STREAM) begin
        oValid_DS        = iValid_AS[grant];
        oReady_AS[grant] = iReady_DS;
      end
      if (res_window) begin
        oValid_BS[grant] = iValid_DB;
        oReady_DB        = iReady_BS[grant];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= GW'(NREQ - 1);
      grant <= '0;
    end else begin
      case (state)
        IDLE: state <= ARB;
        ARB: begin
          if (pick_any) begin
            grant <= pick;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (beat_hs) cnt <= cnt + 1'b1;
          if (last_beat) begin
            if (res_hs) begin
              ptr   <= grant;
              state <= ARB;
            end else begin
              state <= RESULT;
            end
          end
        end
        RESULT: begin
          if (res_hs) begin
            ptr   <= grant;
            state <= ARB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DECODER_WINDOW_ARBITER_STATUS_EN
  always_ff @(posedge iCLK) begin
    if (iRST) oWinCnt <= '0;
    else if (res_hs) oWinCnt <= oWinCnt + 16'd1;
  end

  assign oGrant = grant;
`endif

endmodule

// File: tb/tb_decoder_window_arbiter.sv
// Directed bench for decoder_window_arbiter with a cycle-level behavioural model (WR=2, 4-beat windows).
module tb_decoder_window_arbiter;

  localparam int NREQ  = 4;
  localparam int WDATA = 16;
  localparam int WRES  = 16;
  localparam int WR    = 2;
  localparam int WIN   = 1 << WR;

  logic                  iCLK = 1'b0;
  logic                  iRST;
  logic [NREQ-1:0]       iValid_AS;
  logic [NREQ-1:0]       oReady_AS;
  logic [NREQ*WDATA-1:0] iData_AS;
  logic                  oValid_DS;
  logic                  iReady_DS;
  logic [WDATA-1:0]      oData_DS;
  logic                  iValid_DB;
  logic                  oReady_DB;
  logic [WRES-1:0]       iData_DB;
  logic [NREQ-1:0]       oValid_BS;
  logic [NREQ-1:0]       iReady_BS;
  logic [NREQ*WRES-1:0]  oData_BS;
`ifdef DECODER_WINDOW_ARBITER_STATUS_EN
  logic [1:0]            oGrant;
  logic [15:0]           oWinCnt;
`endif

  int total = 0;
  int bad   = 0;

  decoder_window_arbiter #(
    .NREQ  (NREQ),
    .WDATA (WDATA),
    .WRES  (WRES),
    .WR    (WR)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iValid_AS (iValid_AS),
    .oReady_AS (oReady_AS),
    .iData_AS  (iData_AS),
    .oValid_DS (oValid_DS),
    .iReady_DS (iReady_DS),
    .oData_DS  (oData_DS),
    .iValid_DB (iValid_DB),
    .oReady_DB (oReady_DB),
    .iData_DB  (iData_DB),
    .oValid_BS (oValid_BS),
    .iReady_BS (iReady_BS),
    .oData_BS  (oData_BS)
`ifdef DECODER_WINDOW_ARBITER_STATUS_EN
    ,
    .oGrant    (oGrant),
    .oWinCnt   (oWinCnt)
`endif
  );

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] vas, input logic rds,
                               input logic vdb, input logic [WRES-1:0] ddb, input logic [NREQ-1:0] rbs);
    iRST      = rst;
    iValid_AS = vas;
    iReady_DS = rds;
    iValid_DB = vdb;
    iData_DB  = ddb;
    iReady_BS = rbs;
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Model: who owns the decoder, how many beats it has delivered, whether its result is pending.
  bit          m_on = 1'b0;
  bit          m_fresh;
  bit          m_wait;
  int          m_owner;
  int          m_beats;
  int          m_last;
  int          m_grant;
  logic [15:0] m_wins;

  always @(negedge iCLK) begin : model_cmp
    logic [NREQ-1:0] e_rdy_as;
    logic [NREQ-1:0] e_vbs;
    logic            e_vds;
    logic            e_rdb;
    bit              hs;
    bit              res;
    int              nxt;
    e_rdy_as = '0;
    e_vbs    = '0;
    e_vds    = 1'b0;
    e_rdb    = 1'b0;
    hs       = 1'b0;
    res      = 1'b0;
    nxt      = 0;
    if (m_on && !iRST && !m_fresh && m_owner >= 0) begin
      if (!m_wait) begin
        e_vds             = iValid_AS[m_owner];
        e_rdy_as[m_owner] = iReady_DS;
        hs                = e_vds && iReady_DS;
        if (hs && m_beats == WIN - 1) begin
          e_vbs[m_owner] = iValid_DB;
          e_rdb          = iReady_BS[m_owner];
        end
      end else begin
        e_vbs[m_owner] = iValid_DB;
        e_rdb          = iReady_BS[m_owner];
      end
      res = e_rdb && iValid_DB;
    end
    if (m_on) begin
      checkOutput("m_valid_ds", 64'(oValid_DS), 64'(e_vds));
      checkOutput("m_ready_as", 64'(oReady_AS), 64'(e_rdy_as));
      checkOutput("m_valid_bs", 64'(oValid_BS), 64'(e_vbs));
      checkOutput("m_ready_db", 64'(oReady_DB), 64'(e_rdb));
      checkOutput("m_data_bs", 64'(oData_BS), 64'({NREQ{iData_DB}}));
      if (e_vds) checkOutput("m_data_ds", 64'(oData_DS), 64'(iData_AS[m_owner*WDATA +: WDATA]));
`ifdef DECODER_WINDOW_ARBITER_STATUS_EN
      checkOutput("m_grant", 64'(oGrant), 64'(m_grant));
      checkOutput("m_wincnt", 64'(oWinCnt), 64'(m_wins));
`endif
    end
    if (iRST) begin
      m_on    = 1'b1;
      m_fresh = 1'b1;
      m_wait  = 1'b0;
      m_owner = -1;
      m_beats = 0;
      m_last  = NREQ - 1;
      m_grant = 0;
      m_wins  = '0;
    end else if (m_on) begin
      if (m_fresh) begin
        m_fresh = 1'b0;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          nxt = (m_last + k) % NREQ;
          if (iValid_AS[nxt]) begin
            m_owner = nxt;
            m_grant = nxt;
            break;
          end
        end
      end else if (res) begin
        m_wins  = m_wins + 16'd1;
        m_last  = m_owner;
        m_owner = -1;
        m_wait  = 1'b0;
        m_beats = 0;
      end else if (hs) begin
        if (m_beats == WIN - 1) begin
          m_beats = 0;
          m_wait  = 1'b1;
        end else begin
          m_beats++;
        end
      end
    end
  end

  logic [NREQ-1:0] stall_tbl [12] = '{4'b0101, 4'b0001, 4'b0001, 4'b0101, 4'b0111, 4'b0100,
                                      4'b0000, 4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101};

  initial begin
    int beats;
    int first;
    int wrong;
    int leak;
    iData_AS = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000);
    step();
    step();
    #1;
    checkOutput("rst_valid_ds", 64'(oValid_DS), 64'd0);
    checkOutput("rst_ready_as", 64'(oReady_AS), 64'd0);
    checkOutput("rst_ready_db", 64'(oReady_DB), 64'd0);

    // Case 1: requesters 0 and 2 compete, requester 0 streams its four beats first.
    step();
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b0, 16'h0000, 4'b0001);
    beats = 0; first = -1; wrong = 0; leak = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (oValid_DS && iReady_DS) begin
        if (first < 0) first = c;
        beats++;
        if (oData_DS !== 16'h1111) wrong++;
      end
      if (oReady_AS[2]) leak++;
      step();
    end
    checkOutput("t1_first_beat_cycle", 64'(first), 64'd2);
    checkOutput("t1_beat_count", 64'(beats), 64'd4);
    checkOutput("t1_wrong_data", 64'(wrong), 64'd0);
    checkOutput("t1_req2_ready_leak", 64'(leak), 64'd0);

    // Case 2: result returns to requester 0, then requester 2 takes the next window.
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 16'hBEEF, 4'b0001);
    #1;
    checkOutput("t2_valid_bs", 64'(oValid_BS), 64'h1);
    checkOutput("t2_ready_db", 64'(oReady_DB), 64'h1);
    checkOutput("t2_data_bs", 64'(oData_BS[WRES-1:0]), 64'hBEEF);
    step();
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b0, 16'h0000, 4'b0001);
    #1;
    checkOutput("t2_arb_valid_ds", 64'(oValid_DS), 64'd0);
    step();
    #1;
    checkOutput("t2_grant_req2", 64'(oReady_AS), 64'h4);
    checkOutput("t2_data_req2", 64'(oData_DS), 64'h3333);

    // Case 3: result arrives with the fourth beat, so the next cycle is arbitration.
    step();
    step();
    step();
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 16'hCAFE, 4'b0100);
    #1;
    checkOutput("t3_valid_bs", 64'(oValid_BS), 64'h4);
    checkOutput("t3_ready_db", 64'(oReady_DB), 64'h1);
    step();
    #1;
    checkOutput("t3_arb_ready_db", 64'(oReady_DB), 64'd0);
    checkOutput("t3_arb_valid_bs", 64'(oValid_BS), 64'd0);
    step();
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b0, 16'h0000, 4'b0000);
    #1;
    checkOutput("t3_regrant_req0", 64'(oReady_AS), 64'h1);

    // Case 4: requester 0 withholds result ready for five cycles after its last beat.
    step();
    step();
    step();
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 16'hD00D, 4'b0000);
    #1;
    checkOutput("t4_last_beat_ready_db", 64'(oReady_DB), 64'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      checkOutput("t4_hold_ready_db", 64'(oReady_DB), 64'd0);
      checkOutput("t4_hold_ready_as", 64'(oReady_AS), 64'd0);
    end
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 16'hD00D, 4'b0001);
    #1;
    checkOutput("t4_release_ready_db", 64'(oReady_DB), 64'h1);

    // Case 5: reset lands after two beats of requester 2's window.
    step();
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b0, 16'h0000, 4'b0000);
    step();
    #1;
    checkOutput("t5_grant_req2", 64'(oReady_AS), 64'h4);
    step();
    step();
    applyStimulus(1'b1, 4'b0101, 1'b1, 1'b0, 16'h0000, 4'b0000);
    #1;
    checkOutput("t5_rst_valid_ds", 64'(oValid_DS), 64'd0);
    checkOutput("t5_rst_ready_as", 64'(oReady_AS), 64'd0);
    step();
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 16'h5A5A, 4'b1111);
    #1;
    checkOutput("t5_idle_valid_ds", 64'(oValid_DS), 64'd0);
    checkOutput("t5_idle_ready_db", 64'(oReady_DB), 64'd0);
    step();
    step();
    #1;
    checkOutput("t5_first_grant_req0", 64'(oReady_AS), 64'h1);

    // Case 6: three back-to-back windows with immediate results.
    beats = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (oValid_DS && iReady_DS) beats++;
`ifdef DECODER_WINDOW_ARBITER_STATUS_EN
      if (c == 5) checkOutput("t6_grant_mid", 64'(oGrant), 64'd2);
`endif
      step();
    end
    checkOutput("t6_beats_three_windows", 64'(beats), 64'd12);
`ifdef DECODER_WINDOW_ARBITER_STATUS_EN
    checkOutput("t6_wincnt", 64'(oWinCnt), 64'd3);
    checkOutput("t6_grant_last", 64'(oGrant), 64'd0);
`endif

    // Stalls inside a window and requests changing during arbitration.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, stall_tbl[c], 1'b1, 1'b0, 16'h0000, 4'b0000);
      step();
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 4'b0010, 1'b1, 1'b1, 16'h7E57, 4'b1111);
      step();
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_window_arbiter.md
Name: decoder_window_arbiter

Overview:
- Shares one stochastic-stream decoder datapath among NREQ requesters.
- Grants one requester for a whole conversion window of 2^WR input beats. Streams that requester's data into the decoder, then routes the decoder's single binary result back to the same requester.
- Sits between the reservoir/readout stream producers and a single decoder core instance.
- Requesters never interleave inside a window.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WDATA, 16, width of one stream beat (decoder lanes x stream width).
- WRES, 16, width of one binary result word.
- WR, 8, log2 of beats per conversion window.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  synchronous active-high reset.
- iValid_AS  in  NREQ  per-requester stream beat valid.
- oReady_AS  out  NREQ  per-requester stream beat ready.
- iData_AS  in  NREQ*WDATA  per-requester beat data; requester r uses bits [r*WDATA+:WDATA].
- oValid_DS  out  1  beat valid to decoder.
- iReady_DS  in  1  decoder beat ready.
- oData_DS  out  WDATA  beat data to decoder.
- iValid_DB  in  1  decoder result valid.
- oReady_DB  out  1  result ready to decoder.
- iData_DB  in  WRES  decoder result.
- oValid_BS  out  NREQ  per-requester result valid.
- iReady_BS  in  NREQ  per-requester result ready.
- oData_BS  out  NREQ*WRES  result data, broadcast to all slices.

Behaviour:
- Clocking and reset: one clock, iCLK. Reset iRST is synchronous and active-high.
- Reset, including mid-window: state = IDLE, beat counter = 0, round-robin pointer = NREQ-1 (requester 0 wins first). All valid and ready outputs are 0 in the reset cycle and in IDLE.
- IDLE: always moves to ARB next cycle.
- ARB:
  - If no iValid_AS bit is set, stay in ARB.
  - Otherwise grant the first set bit searching upward from pointer+1, with modulo-NREQ wrap. Register it as grant g and go to STREAM.
  - The grant decision takes one cycle; no beat passes in ARB.
- STREAM:
  - oValid_DS = iValid_AS[g]; oData_DS = iData_AS slice g; oReady_AS[g] = iReady_DS. All other oReady_AS bits are 0.
  - Beat handshake (oValid_DS & iReady_DS) increments the WR-bit counter.
  - The last beat is the handshake when the counter = 2^WR-1.
- Result path (active in STREAM during the last-beat cycle, and in RESULT):
  - oValid_BS[g] = iValid_DB; oReady_DB = iReady_BS[g]; other oValid_BS bits are 0.
  - Outside these windows oReady_DB = 0. A stray iValid_DB is ignored and held off.
- Transitions out of STREAM on the last-beat handshake:
  - If the result handshake occurs in the same cycle, go to ARB and set pointer = g.
  - Otherwise go to RESULT. The counter wraps to 0.
- RESULT: stay until iValid_DB & iReady_BS[g], then go to ARB and set pointer = g.
- Latency and throughput:
  - Requester to decoder is combinational (zero added latency).
  - Best case is 2^WR+1 cycles per window (one ARB cycle plus 2^WR beats).
- Simultaneous events:
  - Requests arriving while a window is open wait. A deasserted iValid_AS[g] mid-window stalls the window and the grant is held.
  - A requester dropping valid in ARB before being granted loses nothing; it is simply not chosen.
- Width rules: data is passed unmodified, with no arithmetic on data. The counter is exactly WR bits and wraps naturally.

Optional Feature:
- Macro: DECODER_WINDOW_ARBITER_STATUS_EN.
- When defined, adds two output ports:
  - oGrant, width $clog2(NREQ): the registered g; 0 after reset.
  - oWinCnt, width 16: count of completed result handshakes; wraps at 2^16; reset to 0.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE=0, ARB=1, STREAM=2, RESULT=3 (2-bit);
  - $clog2(NREQ) grant width;
  - window length 2^WR.
- One natural sub-module, rr_arbiter_pick:
  - combinational round-robin priority search;
  - inputs: request vector and pointer;
  - outputs: grant index and any-request flag.
- Counter, FSM and muxing stay in the top module.

Test Plan:
1. Reset, then requesters 0 and 2 both valid, WR=2, iReady_DS=1:
   - req0 granted after 1 ARB cycle;
   - exactly 4 beats pass with oData_DS = req0 data;
   - oReady_AS[2] stays 0 throughout.
2. Continue case 1, result returned with iReady_BS[0]=1:
   - oValid_BS[0]=1 carrying iData_DB;
   - next grant is req2 (round-robin);
   - then req0 again if it is still requesting.
3. iValid_DB presented in the same cycle as the 4th beat, iReady_BS[0]=1:
   - FSM skips RESULT; ARB occurs the next cycle.
4. iReady_BS[g]=0 for 5 cycles after the last beat:
   - FSM holds RESULT and oReady_DB=0;
   - no new beats are accepted from any requester.
5. iRST asserted after beat 2 of a window:
   - next cycle all outputs are 0 and the counter is 0;
   - first grant afterwards is requester 0.
6. With DECODER_WINDOW_ARBITER_STATUS_EN defined, three completed windows:
   - oWinCnt=3;
   - oGrant tracks the granted index.
